// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: valid/ready burst controller for an asynchronous SRAM.
// Commands describe a single or burst read/write, starting at a word
// address and running for cmd_len+1 words with modulo address wrap.
// Every pin-facing output is a flop so the SRAM sees glitch-free strobes,
// and the tristate pad lives outside this block (split data bus).
//
// Handshakes:
//   cmd_valid/cmd_ready : a command is taken on a clock edge where both are
//                         high. cmd_ready is high only in IDLE, and only
//                         after the first clock edge following reset.
//   wr_valid/wr_ready   : a write word is taken on a clock edge where both
//                         are high. wr_ready follows wr_valid combinationally
//                         while the controller waits for the next write word.
//   rd_valid            : one-cycle pulse with rd_data; there is no ready, so
//                         the consumer must take every pulse.
module sram_burst_ctrl #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int LEN_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    // write data channel
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    // read data channel
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    busy,
    // SRAM side
    output logic [ADDR_WIDTH-1:0]   address_pins,
    output logic [DATA_WIDTH-1:0]   data_pins_out,
    output logic                    data_pins_oe,
    input  logic [DATA_WIDTH-1:0]   data_pins_in,
    output logic                    cs_n,
    output logic                    we_n,
    output logic                    oe_n,
    output logic [DATA_WIDTH/8-1:0] be_n
);

    localparam int BE_W = DATA_WIDTH / 8;
    // Counter wide enough to count 0..WAIT_CYCLES inside one access.
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_FETCH   = 3'd1,
        S_WR_PULSE   = 3'd2,
        S_WR_RECOVER = 3'd3,
        S_RD_ACCESS  = 3'd4,
        S_END        = 3'd5
    } state_t;

    state_t                  state_q,        state_d;
    logic                    ready_en_q,     ready_en_d;
    logic [LEN_WIDTH-1:0]    beats_q,        beats_d;
    logic [ADDR_WIDTH-1:0]   addr_q,         addr_d;
    logic [WCW-1:0]          wait_q,         wait_d;
    logic [ADDR_WIDTH-1:0]   address_pins_q, address_pins_d;
    logic [DATA_WIDTH-1:0]   data_out_q,     data_out_d;
    logic                    data_oe_q,      data_oe_d;
    logic                    cs_n_q,         cs_n_d;
    logic                    we_n_q,         we_n_d;
    logic                    oe_n_q,         oe_n_d;
    logic [BE_W-1:0]         be_n_q,         be_n_d;
    logic                    rd_valid_q,     rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,      rd_data_d;

    logic                    wait_last;
    logic                    last_beat;

    // Handshake outputs are the only combinational outputs; none reach the pins.
    assign cmd_ready = (state_q == S_IDLE) && ready_en_q;
    assign busy      = ~cmd_ready;
    assign wr_ready  = (state_q == S_WR_FETCH) && wr_valid;

    assign wait_last = (wait_q == WAIT_LAST);
    assign last_beat = (beats_q == '0);

    assign address_pins  = address_pins_q;
    assign data_pins_out = data_out_q;
    assign data_pins_oe  = data_oe_q;
    assign cs_n          = cs_n_q;
    assign we_n          = we_n_q;
    assign oe_n          = oe_n_q;
    assign be_n          = be_n_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;

    // Next-state and next-pin logic; pins change on the edge that changes state.
    always_comb begin
        state_d        = state_q;
        ready_en_d     = 1'b1;
        beats_d        = beats_q;
        addr_d         = addr_q;
        wait_d         = wait_q;
        address_pins_d = address_pins_q;
        data_out_d     = data_out_q;
        data_oe_d      = data_oe_q;
        cs_n_d         = cs_n_q;
        we_n_d         = we_n_q;
        oe_n_d         = oe_n_q;
        be_n_d         = be_n_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    beats_d = cmd_len;
                    wait_d  = '0;
                    if (cmd_write) begin
                        // Pins stay quiet until the first write word shows up.
                        state_d = S_WR_FETCH;
                    end else begin
                        // Reads open the SRAM output straight away, all lanes.
                        state_d        = S_RD_ACCESS;
                        address_pins_d = cmd_addr;
                        data_oe_d      = 1'b0;
                        cs_n_d         = 1'b0;
                        oe_n_d         = 1'b0;
                        be_n_d         = '0;
                    end
                end
            end

            S_WR_FETCH: begin
                // Without write data we simply wait; no strobe moves.
                if (wr_valid) begin
                    state_d        = S_WR_PULSE;
                    address_pins_d = addr_q;
                    data_out_d     = wr_data;
                    be_n_d         = ~wr_be;
                    data_oe_d      = 1'b1;
                    cs_n_d         = 1'b0;
                    we_n_d         = 1'b0;
                    wait_d         = '0;
                end
            end

            S_WR_PULSE: begin
                if (wait_last) begin
                    // Release we_n first; address and data stay put for hold time.
                    state_d = S_WR_RECOVER;
                    we_n_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WR_RECOVER: begin
                addr_d = addr_q + 1'b1;
                cs_n_d = 1'b1;
                be_n_d = '1;
                if (last_beat) begin
                    state_d   = S_END;
                    data_oe_d = 1'b0;
                end else begin
                    // Keep driving the bus between beats; nothing else can use it.
                    state_d = S_WR_FETCH;
                    beats_d = beats_q - 1'b1;
                end
            end

            S_RD_ACCESS: begin
                if (wait_last) begin
                    rd_data_d  = data_pins_in;
                    rd_valid_d = 1'b1;
                    wait_d     = '0;
                    if (last_beat) begin
                        state_d = S_END;
                        cs_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        be_n_d  = '1;
                    end else begin
                        // oe_n stays low; only the address steps to the next word.
                        beats_d        = beats_q - 1'b1;
                        addr_d         = addr_q + 1'b1;
                        address_pins_d = addr_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_END: begin
                // One dead cycle with everything released for bus turnaround.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                be_n_d  = '1;
            end
        endcase
    end

    // State and pin registers; reset releases the SRAM without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ready_en_q     <= 1'b0;
            beats_q        <= '0;
            addr_q         <= '0;
            wait_q         <= '0;
            address_pins_q <= '0;
            data_out_q     <= '0;
            data_oe_q      <= 1'b0;
            cs_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            be_n_q         <= '1;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            ready_en_q     <= ready_en_d;
            beats_q        <= beats_d;
            addr_q         <= addr_d;
            wait_q         <= wait_d;
            address_pins_q <= address_pins_d;
            data_out_q     <= data_out_d;
            data_oe_q      <= data_oe_d;
            cs_n_q         <= cs_n_d;
            we_n_q         <= we_n_d;
            oe_n_q         <= oe_n_d;
            be_n_q         <= be_n_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Electrical sanity of the SRAM interface: never fight the SRAM's drivers.
    a_we_inside_cs: assert property (@(posedge clk) disable iff (reset)
        !we_n_q |-> !cs_n_q);
    a_we_oe_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(!we_n_q && !oe_n_q));
    a_we_drives_bus: assert property (@(posedge clk) disable iff (reset)
        !we_n_q |-> data_oe_q);
    a_oe_bus_released: assert property (@(posedge clk) disable iff (reset)
        !oe_n_q |-> !data_oe_q);

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl with WAIT_CYCLES=1 against a small SRAM model.
// Unwritten SRAM words read back as (address[15:0] ^ 16'hC3A5).
module tb_sram_burst_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam int BW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [LW-1:0] cmd_len   = '0;
    logic          wr_valid  = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data   = '0;
    logic [BW-1:0] wr_be     = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] address_pins;
    logic [DW-1:0] data_pins_out;
    logic          data_pins_oe;
    logic [DW-1:0] data_pins_in = '0;
    logic          cs_n, we_n, oe_n;
    logic [BW-1:0] be_n;

    sram_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(1),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .busy         (busy),
        .address_pins (address_pins),
        .data_pins_out(data_pins_out),
        .data_pins_oe (data_pins_oe),
        .data_pins_in (data_pins_in),
        .cs_n         (cs_n),
        .we_n         (we_n),
        .oe_n         (oe_n),
        .be_n         (be_n)
    );

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [int];
    logic [DW-1:0] wr_word;
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] model_val(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[DW-1:0] ^ 16'hC3A5;
    endfunction

    // Byte-lane write while cs_n and we_n are both low.
    always @(posedge clk) begin
        if (!reset && !cs_n && !we_n) begin
            wr_word = model_val(address_pins);
            for (int i = 0; i < BW; i++)
                if (!be_n[i]) wr_word[i*8 +: 8] = data_pins_out[i*8 +: 8];
            mem[int'(address_pins)] = wr_word;
        end
    end

    // Read data settles half a cycle after the address changes.
    always @(negedge clk)
        data_pins_in = (!cs_n && !oe_n) ? model_val(address_pins) : '0;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_be = '0;
    endtask

    task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    endtask

    task automatic do_write_single(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [BW-1:0] be, output int rdy_at,
                                   output int we_lo, output logic [BW-1:0] be_seen,
                                   output logic [DW-1:0] d_seen);
        logic taken;
        taken = 1'b0; rdy_at = -1; we_lo = 0; be_seen = 2'b01; d_seen = '0;
        issue_cmd(1'b1, a, '0);
        wr_valid = 1'b1; wr_data = d; wr_be = be;
        for (int s = 0; s < 40; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (taken) wr_valid = 1'b0;
            #1;
            if (wr_ready) taken = 1'b1;
            if (!we_n) begin we_lo++; be_seen = be_n; d_seen = data_pins_out; end
            if (cmd_ready) begin rdy_at = s; break; end
        end
        drive_idle();
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, output int rdy_at);
        got_q.delete();
        rdy_at = -1;
        issue_cmd(1'b0, a, l);
        for (int s = 0; s < 60; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (rd_valid) got_q.push_back(rd_data);
            if (cmd_ready) begin rdy_at = s; break; end
        end
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        #3 reset = 1'b1;
        #1;
        n_cmp++; if ({cs_n, we_n, oe_n} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes: got %b expected 111", {cs_n, we_n, oe_n}); end
        n_cmp++; if (be_n !== 2'b11) begin n_bad++; $display("FAIL rst_be_n: got %b expected 11", be_n); end
        n_cmp++; if (data_pins_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b expected 0", data_pins_oe); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if ({address_pins, data_pins_out, rd_data} !== '0) begin n_bad++; $display("FAIL rst_regs: addr %h dout %h rdata %h expected 0", address_pins, data_pins_out, rd_data); end
        n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_ready_in_reset: ready %b busy %b expected 0/1", cmd_ready, busy); end
        #5 reset = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_no_edge: got %b expected 0", cmd_ready); end
        #2 clk_en = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_ready_after_edge: ready %b busy %b expected 1/0", cmd_ready, busy); end
    endtask

    task automatic test_single_write();
        int we_lo = 0, first_rdy = -1;
        logic [AW-1:0] a_seen = '0;
        logic [DW-1:0] d_seen = '0;
        logic [BW-1:0] be_seen = '1;
        logic oe_seen = 1'b0, rec_ok = 1'b0;
        issue_cmd(1'b1, 18'h00010, 4'd0);
        wr_valid = 1'b1; wr_data = 16'hBEEF; wr_be = 2'b11;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL sw_ready_at_issue: got %b expected 1", cmd_ready); end
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (s >= 1) wr_valid = 1'b0;
            #1;
            if (s == 0) begin
                n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL sw_wr_ready: got %b expected 1", wr_ready); end
            end
            if (!we_n) begin we_lo++; a_seen = address_pins; d_seen = data_pins_out; be_seen = be_n; oe_seen = data_pins_oe; end
            if (s == 3) rec_ok = (we_n == 1'b1) && (cs_n == 1'b0);
            if (cmd_ready && first_rdy < 0) first_rdy = s;
        end
        n_cmp++; if (we_lo !== 2) begin n_bad++; $display("FAIL sw_we_width: got %0d expected 2", we_lo); end
        n_cmp++; if (a_seen !== 18'h00010) begin n_bad++; $display("FAIL sw_addr: got %h expected 00010", a_seen); end
        n_cmp++; if (d_seen !== 16'hBEEF) begin n_bad++; $display("FAIL sw_data: got %h expected beef", d_seen); end
        n_cmp++; if (be_seen !== 2'b00 || oe_seen !== 1'b1) begin n_bad++; $display("FAIL sw_be_oe: be_n %b oe %b expected 00/1", be_seen, oe_seen); end
        n_cmp++; if (rec_ok !== 1'b1) begin n_bad++; $display("FAIL sw_recover: got %b expected 1", rec_ok); end
        n_cmp++; if (first_rdy !== 5) begin n_bad++; $display("FAIL sw_ready_latency: got %0d expected 5", first_rdy); end
        n_cmp++; if (model_val(18'h00010) !== 16'hBEEF) begin n_bad++; $display("FAIL sw_mem: got %h expected beef", model_val(18'h00010)); end
        drive_idle();
    endtask

    task automatic test_read_wrap();
        logic [AW-1:0] exp_a [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        logic [AW-1:0] seq [8];
        logic [DW-1:0] e;
        int addr_n = 0, pulses = 0, first_p = -1, last_p = -1;
        logic gaps_ok = 1'b1, oe_low_ok = 1'b1, oe_end = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h3C5B); exp_q.push_back(16'h3C5A);
        exp_q.push_back(16'hC3A5); exp_q.push_back(16'hC3A4);
        issue_cmd(1'b0, 18'h3FFFE, 4'd3);
        for (int s = 0; s < 14; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (rd_valid) begin
                pulses++;
                if (first_p < 0) first_p = s;
                if (last_p >= 0 && (s - last_p) != 2) gaps_ok = 1'b0;
                last_p = s;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++; if (rd_data !== e) begin n_bad++; $display("FAIL rw_data: got %h expected %h", rd_data, e); end
                end
            end
            if (s <= 7 && oe_n !== 1'b0) oe_low_ok = 1'b0;
            if (s == 8) oe_end = oe_n;
            if (!cs_n && !oe_n && addr_n < 8 && (addr_n == 0 || address_pins != seq[addr_n-1])) begin
                seq[addr_n] = address_pins;
                addr_n++;
            end
        end
        n_cmp++; if (pulses !== 4 || first_p !== 2) begin n_bad++; $display("FAIL rw_pulses: got %0d first %0d expected 4 first 2", pulses, first_p); end
        n_cmp++; if (gaps_ok !== 1'b1) begin n_bad++; $display("FAIL rw_spacing: got %b expected 1", gaps_ok); end
        n_cmp++; if (oe_low_ok !== 1'b1 || oe_end !== 1'b1) begin n_bad++; $display("FAIL rw_oe_n: low %b end %b expected 1/1", oe_low_ok, oe_end); end
        n_cmp++; if (addr_n !== 4) begin n_bad++; $display("FAIL rw_addr_count: got %0d expected 4", addr_n); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (seq[i] !== exp_a[i]) begin n_bad++; $display("FAIL rw_addr%0d: got %h expected %h", i, seq[i], exp_a[i]); end
        end
        drive_idle();
    endtask

    task automatic test_write_stall();
        logic [DW-1:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
        int b = 0, we_lo = 0, first_rdy = -1;
        logic stall_ok = 1'b1;
        issue_cmd(1'b1, 18'h00100, 4'd2);
        wr_valid = 1'b1; wr_data = words[0]; wr_be = 2'b11;
        for (int s = 0; s < 22; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (b < 3) begin
                wr_valid = !(s >= 4 && s <= 7);
                wr_data = words[b];
            end else begin
                wr_valid = 1'b0;
            end
            #1;
            if (s >= 4 && s <= 7)
                if (we_n !== 1'b1 || cs_n !== 1'b1 || wr_ready !== 1'b0 || address_pins !== 18'h00100) stall_ok = 1'b0;
            if (!we_n) we_lo++;
            if (cmd_ready && first_rdy < 0) first_rdy = s;
            if (wr_ready) b++;
        end
        n_cmp++; if (stall_ok !== 1'b1) begin n_bad++; $display("FAIL ws_stall: got %b expected 1", stall_ok); end
        n_cmp++; if (b !== 3) begin n_bad++; $display("FAIL ws_words_taken: got %0d expected 3", b); end
        n_cmp++; if (we_lo !== 6) begin n_bad++; $display("FAIL ws_we_cycles: got %0d expected 6", we_lo); end
        n_cmp++; if (first_rdy !== 17) begin n_bad++; $display("FAIL ws_ready_latency: got %0d expected 17", first_rdy); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (model_val(AW'(18'h00100 + i)) !== words[i]) begin n_bad++; $display("FAIL ws_mem%0d: got %h expected %h", i, model_val(AW'(18'h00100 + i)), words[i]); end
        end
        drive_idle();
    endtask

    task automatic test_byte_enable();
        int rdy, lo;
        logic [BW-1:0] be_s;
        logic [DW-1:0] d_s;
        do_write_single(18'h00200, 16'hABCD, 2'b11, rdy, lo, be_s, d_s);
        n_cmp++; if (rdy !== 5) begin n_bad++; $display("FAIL be_preload_latency: got %0d expected 5", rdy); end
        do_write_single(18'h00200, 16'h1234, 2'b01, rdy, lo, be_s, d_s);
        n_cmp++; if (be_s !== 2'b10 || lo !== 2) begin n_bad++; $display("FAIL be_lane_pins: be_n %b we_lo %0d expected 10/2", be_s, lo); end
        n_cmp++; if (d_s !== 16'h1234) begin n_bad++; $display("FAIL be_data_pins: got %h expected 1234", d_s); end
        run_read(18'h00200, 4'd0, rdy);
        n_cmp++; if (got_q.size() !== 1 || rdy !== 3) begin n_bad++; $display("FAIL be_read_shape: words %0d ready %0d expected 1/3", got_q.size(), rdy); end
        else begin
            n_cmp++; if (got_q[0] !== 16'hAB34) begin n_bad++; $display("FAIL be_readback: got %h expected ab34", got_q[0]); end
        end
    endtask

    task automatic test_be_zero();
        int rdy, lo;
        logic [BW-1:0] be_s;
        logic [DW-1:0] d_s;
        do_write_single(18'h00200, 16'h5555, 2'b00, rdy, lo, be_s, d_s);
        n_cmp++; if (be_s !== 2'b11 || lo !== 2) begin n_bad++; $display("FAIL bz_masked_cycle: be_n %b we_lo %0d expected 11/2", be_s, lo); end
        run_read(18'h00200, 4'd0, rdy);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL bz_read_count: got %0d expected 1", got_q.size()); end
        else begin
            n_cmp++; if (got_q[0] !== 16'hAB34) begin n_bad++; $display("FAIL bz_unchanged: got %h expected ab34", got_q[0]); end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0, we_lo = 0, wr_rdy = 0;
        logic [DW-1:0] d = '0;
        logic busy_seen = 1'b0, idle_ok = 1'b1;
        issue_cmd(1'b0, 18'h00010, 4'd0);
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            if (s < 2) begin
                cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'h00300; cmd_len = 4'd5;
                wr_valid = 1'b1; wr_data = 16'hDEAD; wr_be = 2'b11;
            end else begin
                drive_idle();
            end
            #1;
            if (s == 0) busy_seen = busy;
            if (rd_valid) begin pulses++; d = rd_data; end
            if (!we_n) we_lo++;
            if (wr_ready) wr_rdy++;
            if (s >= 3 && cmd_ready !== 1'b1) idle_ok = 1'b0;
        end
        n_cmp++; if (busy_seen !== 1'b1) begin n_bad++; $display("FAIL bi_busy: got %b expected 1", busy_seen); end
        n_cmp++; if (pulses !== 1 || d !== 16'hBEEF) begin n_bad++; $display("FAIL bi_read: pulses %0d data %h expected 1/beef", pulses, d); end
        n_cmp++; if (we_lo !== 0 || wr_rdy !== 0) begin n_bad++; $display("FAIL bi_no_write: we_lo %0d wr_ready %0d expected 0/0", we_lo, wr_rdy); end
        n_cmp++; if (idle_ok !== 1'b1) begin n_bad++; $display("FAIL bi_not_queued: got %b expected 1", idle_ok); end
        n_cmp++; if (model_val(18'h00300) !== 16'hC0A5) begin n_bad++; $display("FAIL bi_mem: got %h expected c0a5", model_val(18'h00300)); end
    endtask

    task automatic test_reset_mid_read();
        int pulses = 0, rdy;
        logic [DW-1:0] d = '0;
        logic quiet_ok = 1'b1;
        issue_cmd(1'b0, 18'h00040, 4'd3);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (rd_valid) begin pulses++; d = rd_data; end
        end
        n_cmp++; if (pulses !== 1 || d !== 16'hC3E5) begin n_bad++; $display("FAIL rm_first_beat: pulses %0d data %h expected 1/c3e5", pulses, d); end
        n_cmp++; if (cs_n !== 1'b0 || address_pins !== 18'h00041) begin n_bad++; $display("FAIL rm_in_beat2: cs_n %b addr %h expected 0/00041", cs_n, address_pins); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({cs_n, we_n, oe_n, be_n} !== 5'b11111 || data_pins_oe !== 1'b0) begin n_bad++; $display("FAIL rm_async_release: strobes %b oe %b expected 11111/0", {cs_n, we_n, oe_n, be_n}, data_pins_oe); end
        n_cmp++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rm_rd_ready: rd_valid %b cmd_ready %b expected 0/0", rd_valid, cmd_ready); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            if (rd_valid || !cs_n || !oe_n) quiet_ok = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            #1;
            if (rd_valid || !cs_n || !oe_n) quiet_ok = 1'b0;
        end
        n_cmp++; if (quiet_ok !== 1'b1) begin n_bad++; $display("FAIL rm_quiet_after: got %b expected 1", quiet_ok); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_again: got %b expected 1", cmd_ready); end
        run_read(18'h00041, 4'd1, rdy);
        n_cmp++; if (rdy !== 5 || got_q.size() !== 2) begin n_bad++; $display("FAIL rm_new_read_shape: ready %0d words %0d expected 5/2", rdy, got_q.size()); end
        else begin
            n_cmp++; if (got_q[0] !== 16'hC3E4 || got_q[1] !== 16'hC3E7) begin n_bad++; $display("FAIL rm_new_read_data: got %h %h expected c3e4 c3e7", got_q[0], got_q[1]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_read_wrap();
        test_write_stall();
        test_byte_enable();
        test_be_zero();
        test_busy_ignore();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
Parametrised async-SRAM controller, successor to the single-word iCE40 SRAM interface. It accepts valid/ready commands for single or burst reads and writes, with programmable wait states, byte enables and address wrap. It sits between the system bus and the external SRAM (IS61WV25616-class). The tristate SB_IO is instantiated by the top level, so this block exposes a split data bus.

Parameters:
ADDR_WIDTH, 18, SRAM word-address width
DATA_WIDTH, 16, data width; must be a multiple of 8
WAIT_CYCLES, 1, extra clocks the strobe is held beyond 1 (access = WAIT_CYCLES+1 clocks)
LEN_WIDTH, 4, burst length field width (max burst 2^LEN_WIDTH words)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start word address
cmd_len  in  LEN_WIDTH  burst length minus 1
wr_valid  in  1  write data available
wr_ready  out  1  write word accepted this cycle
wr_data  in  DATA_WIDTH  write word
wr_be  in  DATA_WIDTH/8  byte enables, active high
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATA_WIDTH  read word
busy  out  1  ~cmd_ready
address_pins  out  ADDR_WIDTH  SRAM address
data_pins_out  out  DATA_WIDTH  to SB_IO D_OUT_0
data_pins_oe  out  1  to SB_IO OUTPUT_ENABLE
data_pins_in  in  DATA_WIDTH  from SB_IO D_IN_0
cs_n, we_n, oe_n  out  1 each  SRAM strobes, active low
be_n  out  DATA_WIDTH/8  SRAM byte lanes (LB/UB), active low

Behaviour:
- Reset (async): state=IDLE; cs_n=we_n=oe_n=1; be_n all 1; data_pins_oe=0; rd_valid=0; cmd_ready=0 while reset is high; address_pins, data_pins_out and rd_data=0. Strobes go inactive immediately, without waiting for a clock edge.
- All pin outputs, rd_data and rd_valid are registered. Strobes update on the same edge as the state transition. No combinational path exists from the command inputs to the pins.
- States: IDLE, WR_FETCH, WR_PULSE, WR_RECOVER, RD_ACCESS, END.
- IDLE: cmd_ready=1, all strobes inactive. When cmd_valid is high, latch addr, len and write into a beat counter. A write goes to WR_FETCH; a read goes to RD_ACCESS.
- WR_FETCH: wr_ready=wr_valid (combinational), strobes inactive. When wr_valid is high, register wr_data, ~wr_be and the address, set data_pins_oe=1, and go to WR_PULSE. If wr_valid is low, stall indefinitely with no pin activity.
- WR_PULSE: cs_n=0, we_n=0 and be_n driven for exactly WAIT_CYCLES+1 clocks.
- WR_RECOVER: 1 clock with we_n=1 while address and data are held; cs_n stays 0. Then go to WR_FETCH if beats remain, otherwise END. A write beat takes at least WAIT_CYCLES+3 clocks.
- RD_ACCESS: cs_n=0, oe_n=0, be_n=0, data_pins_oe=0; address held for WAIT_CYCLES+1 clocks. On the final edge, capture data_pins_in into rd_data and assert rd_valid for the next clock only. Then increment the address and repeat without raising oe_n between beats. Beats are spaced WAIT_CYCLES+1 clocks apart. There is no read backpressure; the consumer must accept every pulse. After the last beat, go to END.
- END: 1 clock with all strobes inactive and data_pins_oe=0 (bus turnaround), then IDLE.
- Address increments modulo 2^ADDR_WIDTH, so the burst wraps from the top address to 0.
- wr_be=0 performs the write cycle with all lanes masked; memory contents are unchanged.
- cmd_valid while busy is ignored and not queued.
- Reset mid-burst aborts the burst: no further rd_valid or wr_ready, and the remaining write data is not consumed.

Test Plan:
- Assert reset with clk stopped -> cs_n=we_n=oe_n=1, data_pins_oe=0, rd_valid=0 immediately; cmd_ready=1 one edge after release.
- WAIT_CYCLES=1: write 0xBEEF to 0x00010 with be=11, wr_valid high -> we_n low for exactly 2 clocks, address 0x00010, data_pins_out 0xBEEF, cmd_ready high again 5 clocks after acceptance.
- Read burst from 0x3FFFE with cmd_len=3 against a SRAM model -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; 4 rd_valid pulses 2 clocks apart carrying the model data; oe_n stays low throughout the burst.
- Write burst of 3 with wr_valid dropped for 4 clocks before beat 2 -> controller stalls in WR_FETCH with we_n=1 and address unchanged; all 3 words land at consecutive addresses.
- Write 0x1234 with be=01 over existing 0xABCD, then read back -> be_n=10 during the pulse; readback returns 0xAB34.
- Assert reset during the 2nd beat of a 4-beat read -> strobes go inactive asynchronously, no further rd_valid; after release, a new read returns correct data.
